// File: rtl/alu_pkg.sv
// Shared ALU opcodes, datapath width and the multiplier state encoding.
package alu_pkg;
    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_BUSY = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/mult_seq_if.sv
// Start/result handshake of the sequential multiplier.
interface mult_seq_if #(parameter int WIDTH = 32);
    logic             StartValid;
    logic             StartReady;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             ResultValid;
    logic             ResultAck;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (output StartValid, OpA, OpB, ResultAck,
                    input  StartReady, ResultValid, Hi, Lo);
    modport slave  (input  StartValid, OpA, OpB, ResultAck,
                    output StartReady, ResultValid, Hi, Lo);
endinterface

// File: rtl/mult_seq.sv
// Shift-add 32x32->64 multiplier borrowing a shared ALU for its adds.
// Define MULT_SIGNED_EN to add the Signed input (signed operands via magnitudes).
module mult_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULT_SIGNED_EN
    input  logic             Signed,
`endif
    mult_seq_if.slave        bus,
    output logic             AluReq,
    input  logic             AluGnt,
    output logic [2:0]       AluCtl,
    output logic [WIDTH-1:0] AluDataA,
    output logic [WIDTH-1:0] AluDataB,
    output logic [4:0]       AluShamt,
    input  logic [WIDTH-1:0] AluDataOut
);
    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] hi_q, lo_q, mcand;
    logic             accept, op_zero, last;
    logic [WIDTH-1:0] a_mag, b_mag, s;
    logic             c;
    logic [2*WIDTH-1:0] step, fin;
`ifdef MULT_SIGNED_EN
    logic             neg_q;
`endif

    assign accept  = bus.StartValid && (state == S_IDLE);
    assign op_zero = (bus.OpA == '0) || (bus.OpB == '0);
    assign last    = (cnt == 5'd31);

    assign bus.StartReady  = (state == S_IDLE);
    assign bus.ResultValid = (state == S_DONE);
    assign bus.Hi          = hi_q;
    assign bus.Lo          = lo_q;

    assign AluReq   = (state == S_BUSY);
    assign AluCtl   = AluReq ? ALU_ADD : 3'b000;
    assign AluDataA = AluReq ? hi_q : '0;
    assign AluDataB = AluReq ? mcand : '0;
    assign AluShamt = 5'd0;

    always_comb begin
        a_mag = bus.OpA;
        b_mag = bus.OpB;
`ifdef MULT_SIGNED_EN
        if (Signed && bus.OpA[WIDTH-1]) a_mag = -bus.OpA;
        if (Signed && bus.OpB[WIDTH-1]) b_mag = -bus.OpB;
`endif
        // The ALU sum wraps iff it comes out below the addend already in Hi.
        s    = lo_q[0] ? AluDataOut : hi_q;
        c    = lo_q[0] && (AluDataOut < hi_q);
        step = {c, s, lo_q[WIDTH-1:1]};
        fin  = step;
`ifdef MULT_SIGNED_EN
        if (neg_q) fin = -step;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mcand <= '0;
`ifdef MULT_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    cnt   <= '0;
                    hi_q  <= '0;
                    mcand <= op_zero ? '0 : a_mag;
                    lo_q  <= op_zero ? '0 : b_mag;
                    state <= op_zero ? S_DONE : S_BUSY;
`ifdef MULT_SIGNED_EN
                    neg_q <= Signed && (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
`endif
                end
                S_BUSY: if (AluGnt) begin
                    {hi_q, lo_q} <= last ? fin : step;
                    cnt          <= cnt + 5'd1;
                    if (last) state <= S_DONE;
                end
                S_DONE: if (bus.ResultAck) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
